// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, parity modes and the baud divisor function.
// Kept in one package so the receiver can use the same table.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_state_e;

  typedef enum logic [1:0] {
    ParNone    = 2'd0,
    ParOdd     = 2'd1,
    ParEven    = 2'd2,
    ParNoneAlt = 2'd3
  } parity_e;

  // Rounded clocks per bit for the selected baud rate.
  function automatic int unsigned bit_cyc(input int unsigned clk_freq,
                                          input logic [2:0]  baud_set);
    int unsigned baud;
    case (baud_set)
      3'd0:    baud = 9600;
      3'd1:    baud = 19200;
      3'd2:    baud = 38400;
      3'd3:    baud = 57600;
      3'd4:    baud = 115200;
      3'd5:    baud = 230400;
      3'd6:    baud = 460800;
      default: baud = 921600;
    endcase
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period tick generator; the count sits at zero while disabled so each
// frame starts a fresh bit period.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ena,
  input  logic [2:0] baud_set,
  output logic       bit_tick
);

  localparam int unsigned CntW = $clog2(bit_cyc(CLK_FREQ, 3'd0));

  logic [CntW-1:0] div_max [8];
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            at_max;

  for (genvar i = 0; i < 8; i++) begin : g_div
    assign div_max[i] = CntW'(bit_cyc(CLK_FREQ, 3'(i)) - 1);
  end

  always_comb begin
    at_max   = (cnt_q == div_max[baud_set]);
    bit_tick = ena && at_max;
    cnt_d    = cnt_q;
    if (!ena || at_max) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// UART transmitter with runtime baud, parity and stop-bit selection.
// All frame configuration is captured at accept; tx comes straight from a flop.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50000000,
  parameter int unsigned DATA_W   = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              tx_en,
  input  logic [2:0]        baud_set,
  input  logic [1:0]        parity_mode,
  input  logic              stop2,
  input  logic [DATA_W-1:0] data_byte,
  output logic              tx,
  output logic              tx_done,
  output logic              uart_state
);

  uart_state_e       state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [2:0]        baud_q, baud_d;
  logic              par_en_q, par_en_d;
  logic              par_bit_q, par_bit_d;
  logic              stop2_q, stop2_d;
  logic              stop_cnt_q, stop_cnt_d;
  logic              tx_q, tx_d;
  logic              done_q, done_d;
  logic              bit_tick;

  uart_baud_gen #(
    .CLK_FREQ(CLK_FREQ)
  ) u_baud_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .ena     (state_q != StIdle),
    .baud_set(baud_q),
    .bit_tick(bit_tick)
  );

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    baud_d     = baud_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    stop2_d    = stop2_q;
    stop_cnt_d = stop_cnt_q;
    tx_d       = tx_q;
    done_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (tx_en) begin
          shift_d   = data_byte;
          baud_d    = baud_set;
          stop2_d   = stop2;
          par_en_d  = (parity_mode == ParOdd) || (parity_mode == ParEven);
          // Parity is fixed at accept so later input changes cannot leak in.
          par_bit_d = (parity_mode == ParOdd) ? ~^data_byte : ^data_byte;
          bit_cnt_d = '0;
          tx_d      = 1'b0;
          state_d   = StStart;
        end
      end
      StStart: begin
        if (bit_tick) begin
          tx_d    = shift_q[0];
          state_d = StData;
        end
      end
      StData: begin
        if (bit_tick) begin
          if (bit_cnt_q == 4'(DATA_W - 1)) begin
            stop_cnt_d = 1'b0;
            if (par_en_q) begin
              tx_d    = par_bit_q;
              state_d = StParity;
            end else begin
              tx_d    = 1'b1;
              state_d = StStop;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            shift_d   = shift_q >> 1;
            tx_d      = shift_d[0];
          end
        end
      end
      StParity: begin
        if (bit_tick) begin
          tx_d       = 1'b1;
          stop_cnt_d = 1'b0;
          state_d    = StStop;
        end
      end
      StStop: begin
        tx_d = 1'b1;
        if (bit_tick) begin
          if (stop2_q && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
          end else begin
            done_d  = 1'b1;
            state_d = StIdle;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      baud_q     <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop2_q    <= 1'b0;
      stop_cnt_q <= 1'b0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      baud_q     <= baud_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      stop2_q    <= stop2_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
    end
  end

  assign tx         = tx_q;
  assign tx_done    = done_q;
  assign uart_state = (state_q != StIdle);

endmodule
